// File: rtl/tl_ul_pkg.sv
// TL-UL shared definitions: opcode encodings, A/D beat header structs and the
// byte-lane helper used by responders and monitors on the 32-bit port.
package tl_ul_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;

    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] param;
        logic [1:0] size;
        logic [3:0] mask;
    } tl_a_hdr_t;

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] param;
        logic [1:0] size;
        logic       denied;
        logic       corrupt;
    } tl_d_hdr_t;

    // Lanes a naturally aligned access of 2^size bytes at addr_lo touches.
    function automatic logic [3:0] mask_for(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'd0:    return 4'b0001 << addr_lo;
            2'd1:    return addr_lo[1] ? 4'b1100 : 4'b0011;
            2'd2:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/tl_ul_scratch_ram.sv
// Flop-based word RAM with per-byte write enables; synchronous write and
// asynchronous read so a response can be formed in the request cycle.
module tl_ul_scratch_ram #(
    parameter int WORD_AW = 7,
    parameter int DATA_W  = 32
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   wmask,
    input  logic [WORD_AW-1:0]    addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**WORD_AW];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/tl_ul_scratch_responder.sv
// TL-UL manager terminating one A/D pair onto a scratch RAM; Get/PutFull/
// PutPartial answered one cycle later from a single-entry D register.
module tl_ul_scratch_responder
    import tl_ul_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int SOURCE_W = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [1:0]          a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [3:0]          a_mask,
    input  logic [DATA_W-1:0]   a_data,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [1:0]          d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic                d_denied,
    output logic                d_corrupt,
    output logic [DATA_W-1:0]   d_data
);

    typedef enum logic {EMPTY, FULL} resp_state_e;

    tl_a_hdr_t           a_hdr_p0;
    tl_d_hdr_t           d_hdr_p0;
    tl_d_hdr_t           d_hdr_p1;
    resp_state_e         state_p1;
    logic [SOURCE_W-1:0] d_source_p1;
    logic [DATA_W-1:0]   d_data_p0;
    logic [DATA_W-1:0]   d_data_p1;
    logic [DATA_W-1:0]   rdata_p0;
    logic [3:0]          mask_exp_p0;
    logic                aligned_p0;
    logic                legal_p0;
    logic                is_get_p0;
    logic                is_put_p0;
    logic                fire_a;
    logic                fire_d;
    logic                unused_a_param;

    assign a_hdr_p0       = '{opcode: a_opcode, param: a_param, size: a_size, mask: a_mask};
    assign unused_a_param = ^a_hdr_p0.param;

    assign d_valid = (state_p1 == FULL);
    assign a_ready = ~d_valid | d_ready;
    assign fire_a  = a_valid & a_ready;
    assign fire_d  = d_valid & d_ready;

    always_comb begin
        mask_exp_p0 = mask_for(a_hdr_p0.size, a_address[1:0]);
        case (a_hdr_p0.size)
            2'd0:    aligned_p0 = 1'b1;
            2'd1:    aligned_p0 = ~a_address[0];
            2'd2:    aligned_p0 = (a_address[1:0] == 2'b00);
            default: aligned_p0 = 1'b0;
        endcase
        is_get_p0 = (a_hdr_p0.opcode == GET);
        is_put_p0 = (a_hdr_p0.opcode == PUT_FULL) || (a_hdr_p0.opcode == PUT_PARTIAL);
        case (a_hdr_p0.opcode)
            PUT_FULL:    legal_p0 = aligned_p0 && (a_hdr_p0.mask == mask_exp_p0);
            PUT_PARTIAL: legal_p0 = aligned_p0 && ((a_hdr_p0.mask & ~mask_exp_p0) == 4'b0000);
            GET:         legal_p0 = aligned_p0;
            default:     legal_p0 = 1'b0;
        endcase
        d_hdr_p0.opcode  = is_get_p0 ? ACCESS_ACK_DATA : ACCESS_ACK;
        d_hdr_p0.param   = 2'b00;
        d_hdr_p0.size    = a_hdr_p0.size;
        d_hdr_p0.denied  = ~legal_p0;
        d_hdr_p0.corrupt = is_get_p0 & ~legal_p0;
        d_data_p0        = (is_get_p0 && legal_p0) ? rdata_p0 : '0;
    end

    tl_ul_scratch_ram #(
        .WORD_AW (ADDR_W - 2),
        .DATA_W  (DATA_W)
    ) u_ram (
        .clock (clock),
        .we    (fire_a & legal_p0 & is_put_p0),
        .wmask (a_hdr_p0.mask),
        .addr  (a_address[ADDR_W-1:2]),
        .wdata (a_data),
        .rdata (rdata_p0)
    );

    // p0 -> p1: response register; a new beat may load while the old one drains.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_p1    <= EMPTY;
            d_hdr_p1    <= '0;
            d_source_p1 <= '0;
            d_data_p1   <= '0;
        end else begin
            case (state_p1)
                EMPTY:   if (fire_a) state_p1 <= FULL;
                FULL:    if (fire_d && !fire_a) state_p1 <= EMPTY;
                default: state_p1 <= EMPTY;
            endcase
            if (fire_a) begin
                d_hdr_p1    <= d_hdr_p0;
                d_source_p1 <= a_source;
                d_data_p1   <= d_data_p0;
            end
        end
    end

    assign d_opcode  = d_hdr_p1.opcode;
    assign d_param   = d_hdr_p1.param;
    assign d_size    = d_hdr_p1.size;
    assign d_denied  = d_hdr_p1.denied;
    assign d_corrupt = d_hdr_p1.corrupt;
    assign d_source  = d_source_p1;
    assign d_data    = d_data_p1;

endmodule

// File: tb/tb_tl_ul_scratch_responder.sv
// Directed bench for tl_ul_scratch_responder: inputs driven on negedge,
// outputs checked on negedge after the firing posedge.
module tb_tl_ul_scratch_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [0:0]  a_source;
    logic [8:0]  a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [1:0]  d_size;
    logic [0:0]  d_source;
    logic        d_denied;
    logic        d_corrupt;
    logic [31:0] d_data;

    int checks = 0;
    int errors = 0;

    tl_ul_scratch_responder dut (
        .clock     (clock),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_denied  (d_denied),
        .d_corrupt (d_corrupt),
        .d_data    (d_data)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request; it fires on the next posedge when a_ready is high.
    task automatic drive(input logic [2:0] op, input logic [1:0] sz, input logic [8:0] addr,
                         input logic [3:0] m, input logic [31:0] dat, input logic src);
        a_valid   = 1'b1;
        a_opcode  = op;
        a_size    = sz;
        a_address = addr;
        a_mask    = m;
        a_data    = dat;
        a_source  = src;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] sz, input logic [8:0] addr,
                         input logic [3:0] m, input logic [31:0] dat, input logic src);
        drive(op, sz, addr, m, dat, src);
        @(posedge clock);
        #1 a_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic chk_d(input string tag, input logic [2:0] op, input logic [1:0] sz,
                         input logic src, input logic den, input logic cor, input logic [31:0] dat);
        chk({tag, ".valid"},   32'(d_valid),   32'd1);
        chk({tag, ".opcode"},  32'(d_opcode),  32'(op));
        chk({tag, ".param"},   32'(d_param),   32'd0);
        chk({tag, ".size"},    32'(d_size),    32'(sz));
        chk({tag, ".source"},  32'(d_source),  32'(src));
        chk({tag, ".denied"},  32'(d_denied),  32'(den));
        chk({tag, ".corrupt"}, 32'(d_corrupt), 32'(cor));
        chk({tag, ".data"},    d_data,         dat);
    endtask

    initial begin
        reset     = 1'b1;
        d_ready   = 1'b1;
        a_valid   = 1'b0;
        a_opcode  = 3'd0;
        a_param   = 3'd0;
        a_size    = 2'd0;
        a_source  = 1'b0;
        a_address = 9'd0;
        a_mask    = 4'd0;
        a_data    = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst.d_valid",   32'(d_valid),   32'd0);
        chk("rst.d_opcode",  32'(d_opcode),  32'd0);
        chk("rst.d_size",    32'(d_size),    32'd0);
        chk("rst.d_source",  32'(d_source),  32'd0);
        chk("rst.d_denied",  32'(d_denied),  32'd0);
        chk("rst.d_corrupt", 32'(d_corrupt), 32'd0);
        chk("rst.d_data",    d_data,         32'd0);
        chk("rst.a_ready",   32'(a_ready),   32'd1);
        reset = 1'b0;

        // Put then read back
        issue(3'd0, 2'd2, 9'h010, 4'hF, 32'hDEADBEEF, 1'b1);
        chk_d("putfull", 3'd0, 2'd2, 1'b1, 1'b0, 1'b0, 32'h0);
        issue(3'd4, 2'd2, 9'h010, 4'h0, 32'h0, 1'b0);
        chk_d("get1", 3'd1, 2'd2, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);

        // Byte lane write
        issue(3'd1, 2'd0, 9'h012, 4'h4, 32'h00AA0000, 1'b1);
        chk_d("putpart", 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0);
        issue(3'd4, 2'd2, 9'h010, 4'h0, 32'h0, 1'b1);
        chk_d("get2", 3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 32'hDEAABEEF);

        // Illegal requests
        issue(3'd4, 2'd2, 9'h011, 4'hF, 32'h0, 1'b0);
        chk_d("get_misalign", 3'd1, 2'd2, 1'b0, 1'b1, 1'b1, 32'h0);
        issue(3'd2, 2'd2, 9'h010, 4'hF, 32'h0, 1'b1);
        chk_d("bad_opcode", 3'd0, 2'd2, 1'b1, 1'b1, 1'b0, 32'h0);
        issue(3'd0, 2'd1, 9'h010, 4'hF, 32'h12345678, 1'b0);
        chk_d("putfull_badmask", 3'd0, 2'd1, 1'b0, 1'b1, 1'b0, 32'h0);
        issue(3'd4, 2'd3, 9'h010, 4'h0, 32'h0, 1'b1);
        chk_d("get_size3", 3'd1, 2'd3, 1'b1, 1'b1, 1'b1, 32'h0);
        issue(3'd1, 2'd2, 9'h010, 4'h0, 32'hFFFFFFFF, 1'b1);
        chk_d("putpart_mask0", 3'd0, 2'd2, 1'b1, 1'b0, 1'b0, 32'h0);
        issue(3'd4, 2'd2, 9'h010, 4'h0, 32'h0, 1'b0);
        chk_d("get_unchanged", 3'd1, 2'd2, 1'b0, 1'b0, 1'b0, 32'hDEAABEEF);

        // Backpressure
        issue(3'd0, 2'd2, 9'h020, 4'hF, 32'h11111111, 1'b0);
        issue(3'd0, 2'd2, 9'h024, 4'hF, 32'h22222222, 1'b0);
        @(negedge clock);
        chk("bp.idle_valid", 32'(d_valid), 32'd0);
        d_ready = 1'b0;
        drive(3'd4, 2'd2, 9'h020, 4'h0, 32'h0, 1'b0);
        @(posedge clock);
        #1 drive(3'd4, 2'd2, 9'h024, 4'h0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("bp.a_ready_low", 32'(a_ready), 32'd0);
            chk_d("bp.first_held", 3'd1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h11111111);
        end
        d_ready = 1'b1;
        #1 chk("bp.a_ready_flow", 32'(a_ready), 32'd1);
        @(posedge clock);
        #1 a_valid = 1'b0;
        @(negedge clock);
        chk_d("bp.second", 3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 32'h22222222);
        @(negedge clock);
        chk("bp.drained", 32'(d_valid), 32'd0);

        // Streaming alternating Put/Get
        for (int i = 0; i < 8; i++) begin
            logic [8:0]  addr;
            logic [31:0] val;
            addr = 9'h040 + 9'(4 * (i / 2));
            val  = 32'hA5000000 + 32'(i - (i % 2));
            chk("stream.a_ready", 32'(a_ready), 32'd1);
            drive((i % 2 == 0) ? 3'd0 : 3'd4, 2'd2, addr, 4'hF, val, 1'(i % 2));
            @(posedge clock);
            @(negedge clock);
            if (i % 2 == 0)
                chk_d("stream.put", 3'd0, 2'd2, 1'(i % 2), 1'b0, 1'b0, 32'h0);
            else
                chk_d("stream.get", 3'd1, 2'd2, 1'(i % 2), 1'b0, 1'b0, val);
        end
        a_valid = 1'b0;
        @(negedge clock);
        chk("stream.drained", 32'(d_valid), 32'd0);

        // Reset mid-response
        d_ready = 1'b0;
        issue(3'd4, 2'd2, 9'h010, 4'h0, 32'h0, 1'b1);
        chk("rstmid.pending", 32'(d_valid), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("rstmid.d_valid", 32'(d_valid), 32'd0);
        chk("rstmid.a_ready", 32'(a_ready), 32'd1);
        chk("rstmid.d_data",  d_data,       32'd0);
        reset   = 1'b0;
        d_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("rstmid.no_beat", 32'(d_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
